// File: rtl/uart_rx_line_collect.sv
// uart_rx_line_collect
// Assembles bytes from the UART receiver into a fixed-width ASCII line
// (parm_LINE_CHARS space-padded slots followed by CR LF, slot 0 at the MSBs)
// and hands the completed line to the consumer with a valid/ready handshake.
// Optional build macro: UART_RX_LINE_BACKSPACE_EN (BS/DEL erase the last slot).
module uart_rx_line_collect #(
    parameter int unsigned parm_LINE_CHARS = 32,
    parameter logic [7:0]  parm_TERM_CHAR  = 8'h0A
) (
    input  logic                             i_clk_20mhz,
    input  logic                             i_rstn_20mhz,
    input  logic [7:0]                       i_rx_data,
    input  logic                             i_rx_valid,
    output logic [(parm_LINE_CHARS+2)*8-1:0] o_line_ascii,
    output logic                             o_line_valid,
    input  logic                             i_line_ready,
    output logic [5:0]                       o_line_len,
    output logic                             o_line_ovf,
    output logic                             o_rx_drop
);

    localparam int unsigned        LINE_W     = (parm_LINE_CHARS + 2) * 8;
    localparam logic [LINE_W-1:0]  LINE_BLANK = {{parm_LINE_CHARS{8'h20}}, 8'h0D, 8'h0A};
    localparam logic [5:0]         LEN_MAX    = 6'(parm_LINE_CHARS);
    localparam logic [7:0]         CHAR_CR    = 8'h0D;
    localparam logic [7:0]         CHAR_SP    = 8'h20;

    typedef enum logic {
        ST_RXLINE_COLLECT,
        ST_RXLINE_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [LINE_W-1:0]   line_q,  line_d;
    logic [5:0]          len_q,   len_d;
    logic                ovf_q,   ovf_d;
    logic                drop_q,  drop_d;
    logic                rx_is_erase;

`ifdef UART_RX_LINE_BACKSPACE_EN
    assign rx_is_erase = (i_rx_data == 8'h08) || (i_rx_data == 8'h7F);
`else
    assign rx_is_erase = 1'b0;
`endif

    // Next-state logic: collect characters, then hold the line until accepted.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        drop_d  = 1'b0;

        case (state_q)
            ST_RXLINE_COLLECT: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CHAR_CR) begin
                        // CR is implied by the fixed tail; nothing to store.
                    end else if (i_rx_data == parm_TERM_CHAR) begin
                        state_d = ST_RXLINE_DONE;
                    end else if (rx_is_erase) begin
                        if (len_q != 6'd0) begin
                            for (int unsigned i = 0; i < parm_LINE_CHARS; i++) begin
                                if (len_q == 6'(i + 1)) begin
                                    line_d[LINE_W-1-8*i -: 8] = CHAR_SP;
                                end
                            end
                            len_d = len_q - 6'd1;
                        end
                    end else if (len_q < LEN_MAX) begin
                        for (int unsigned i = 0; i < parm_LINE_CHARS; i++) begin
                            if (len_q == 6'(i)) begin
                                line_d[LINE_W-1-8*i -: 8] = i_rx_data;
                            end
                        end
                        len_d = len_q + 6'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end

            ST_RXLINE_DONE: begin
                drop_d = i_rx_valid;
                if (i_line_ready) begin
                    state_d = ST_RXLINE_COLLECT;
                    line_d  = LINE_BLANK;
                    len_d   = 6'd0;
                    ovf_d   = 1'b0;
                end
            end

            default: begin
                state_d = ST_RXLINE_COLLECT;
            end
        endcase
    end

    // State and output registers; reset restores a blank line.
    always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
        if (!i_rstn_20mhz) begin
            state_q <= ST_RXLINE_COLLECT;
            line_q  <= LINE_BLANK;
            len_q   <= 6'd0;
            ovf_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    assign o_line_ascii = line_q;
    assign o_line_valid = (state_q == ST_RXLINE_DONE);
    assign o_line_len   = len_q;
    assign o_line_ovf   = ovf_q;
    assign o_rx_drop    = drop_q;

endmodule

// File: tb/tb_uart_rx_line_collect.sv
// Testbench for uart_rx_line_collect: randomized and directed byte streams
// checked against a queue-based model of the line contents.
module tb_uart_rx_line_collect;

    localparam int N  = 32;
    localparam int W  = (N + 2) * 8;
    localparam int SW = W + 9;
    localparam logic [7:0] LF = 8'h0A;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          line_ready = 1'b0;
    logic [W-1:0]  line_ascii;
    logic          line_valid;
    logic [5:0]    line_len;
    logic          line_ovf;
    logic          rx_drop;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: characters held, overflow flag, line pending, drop pulse.
    logic [7:0] mdl_q[$];
    bit         mdl_ovf;
    bit         mdl_pending;
    bit         mdl_drop;

    uart_rx_line_collect #(
        .parm_LINE_CHARS(N),
        .parm_TERM_CHAR (8'h0A)
    ) dut (
        .i_clk_20mhz (clk),
        .i_rstn_20mhz(rstn),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .o_line_ascii(line_ascii),
        .o_line_valid(line_valid),
        .i_line_ready(line_ready),
        .o_line_len  (line_len),
        .o_line_ovf  (line_ovf),
        .o_rx_drop   (rx_drop)
    );

    always #25 clk = ~clk;

    function automatic logic [W-1:0] exp_line();
        logic [W-1:0] l;
        l = '0;
        for (int i = 0; i < N; i++)
            l[W-1-8*i -: 8] = (i < mdl_q.size()) ? mdl_q[i] : 8'h20;
        l[15:0] = 16'h0D0A;
        return l;
    endfunction

    function automatic logic [SW-1:0] mdl_snap();
        return {mdl_pending, mdl_drop, mdl_ovf, 6'(mdl_q.size()), exp_line()};
    endfunction

    function automatic logic [SW-1:0] dut_snap();
        return {line_valid, rx_drop, line_ovf, line_len, line_ascii};
    endfunction

    task automatic model_reset();
        mdl_q.delete();
        mdl_ovf     = 0;
        mdl_pending = 0;
        mdl_drop    = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] b, input bit rdy);
        if (mdl_pending) begin
            mdl_drop = v;
            if (rdy) begin
                mdl_pending = 0;
                mdl_q.delete();
                mdl_ovf = 0;
            end
        end else begin
            mdl_drop = 0;
            if (v) begin
                if (b == 8'h0D) begin
                end else if (b == LF) begin
                    mdl_pending = 1;
`ifdef UART_RX_LINE_BACKSPACE_EN
                end else if (b == 8'h08 || b == 8'h7F) begin
                    if (mdl_q.size() > 0) void'(mdl_q.pop_back());
`endif
                end else if (mdl_q.size() < N) begin
                    mdl_q.push_back(b);
                end else begin
                    mdl_ovf = 1;
                end
            end
        end
    endtask

    // One clock: inputs applied at a falling edge, sampled by the next
    // rising edge, outputs observed at the following falling edge.
    task automatic cycle(input bit v, input logic [7:0] b, input bit rdy);
        rx_valid   = v;
        rx_data    = b;
        line_ready = rdy;
        @(negedge clk);
        model_step(v, b, rdy);
        rx_valid   = 1'b0;
        line_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        n_checks++;
        if (dut_snap() !== mdl_snap()) begin
            n_fail++;
            $display("FAIL reset_hold: got %h want %h", dut_snap(), mdl_snap());
        end
        rstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dut_snap() !== mdl_snap()) begin
            n_fail++;
            $display("FAIL reset_release: got %h want %h", dut_snap(), mdl_snap());
        end
    endtask

    task automatic test_basic();
        logic [7:0] s[4];
        s = '{"A", "B", 8'h0D, LF};
        for (int i = 0; i < 4; i++) begin
            cycle(1, s[i], 0);
            n_checks++;
            if (dut_snap() !== mdl_snap()) begin
                n_fail++;
                $display("FAIL basic_byte%0d: got %h want %h", i, dut_snap(), mdl_snap());
            end
        end
        cycle(0, 8'h00, 1);
        n_checks++;
        if (dut_snap() !== mdl_snap()) begin
            n_fail++;
            $display("FAIL basic_accept: got %h want %h", dut_snap(), mdl_snap());
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 40; i++) cycle(1, 8'h78, 0);
        n_checks++;
        if (dut_snap() !== mdl_snap()) begin
            n_fail++;
            $display("FAIL ovf_fill: got %h want %h", dut_snap(), mdl_snap());
        end
        cycle(1, LF, 0);
        n_checks++;
        if (dut_snap() !== mdl_snap()) begin
            n_fail++;
            $display("FAIL ovf_line: got %h want %h", dut_snap(), mdl_snap());
        end
        cycle(0, 8'h00, 1);
        n_checks++;
        if (dut_snap() !== mdl_snap()) begin
            n_fail++;
            $display("FAIL ovf_accept: got %h want %h", dut_snap(), mdl_snap());
        end
    endtask

    task automatic test_pending_drop();
        cycle(1, "Q", 0);
        cycle(1, LF, 0);
        for (int i = 0; i < 100; i++) begin
            cycle(0, 8'h00, 0);
            n_checks++;
            if (dut_snap() !== mdl_snap()) begin
                n_fail++;
                $display("FAIL pend_hold%0d: got %h want %h", i, dut_snap(), mdl_snap());
            end
        end
        cycle(1, "Z", 0);
        n_checks++;
        if (dut_snap() !== mdl_snap()) begin
            n_fail++;
            $display("FAIL pend_drop: got %h want %h", dut_snap(), mdl_snap());
        end
        cycle(0, 8'h00, 0);
        n_checks++;
        if (dut_snap() !== mdl_snap()) begin
            n_fail++;
            $display("FAIL pend_drop_end: got %h want %h", dut_snap(), mdl_snap());
        end
        cycle(0, 8'h00, 1);
        n_checks++;
        if (dut_snap() !== mdl_snap()) begin
            n_fail++;
            $display("FAIL pend_accept: got %h want %h", dut_snap(), mdl_snap());
        end
    endtask

    task automatic test_empty_line();
        cycle(1, LF, 0);
        n_checks++;
        if (dut_snap() !== mdl_snap()) begin
            n_fail++;
            $display("FAIL empty_line: got %h want %h", dut_snap(), mdl_snap());
        end
        cycle(0, 8'h00, 1);
        n_checks++;
        if (dut_snap() !== mdl_snap()) begin
            n_fail++;
            $display("FAIL empty_accept: got %h want %h", dut_snap(), mdl_snap());
        end
    endtask

    task automatic test_backspace();
        logic [7:0] s[7];
        s = '{8'h7F, "A", "B", "C", 8'h08, "D", LF};
        for (int i = 0; i < 7; i++) cycle(1, s[i], 0);
        n_checks++;
        if (dut_snap() !== mdl_snap()) begin
            n_fail++;
            $display("FAIL backspace_line: got %h want %h", dut_snap(), mdl_snap());
        end
        cycle(0, 8'h00, 1);
    endtask

    task automatic test_reset_mid();
        cycle(1, "H", 0);
        cycle(1, "E", 0);
        cycle(1, "L", 0);
        rstn = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (dut_snap() !== mdl_snap()) begin
            n_fail++;
            $display("FAIL reset_async: got %h want %h", dut_snap(), mdl_snap());
        end
        @(negedge clk);
        rstn = 1'b1;
        cycle(1, "O", 0);
        cycle(1, "K", 0);
        cycle(1, LF, 0);
        n_checks++;
        if (dut_snap() !== mdl_snap()) begin
            n_fail++;
            $display("FAIL reset_mid_line: got %h want %h", dut_snap(), mdl_snap());
        end
        cycle(0, 8'h00, 1);
    endtask

    task automatic test_back_to_back();
        cycle(1, "K", 0);
        cycle(1, LF, 0);
        cycle(1, "M", 1);
        n_checks++;
        if (dut_snap() !== mdl_snap()) begin
            n_fail++;
            $display("FAIL b2b_hs_drop: got %h want %h", dut_snap(), mdl_snap());
        end
        cycle(1, "N", 0);
        cycle(1, LF, 0);
        n_checks++;
        if (dut_snap() !== mdl_snap()) begin
            n_fail++;
            $display("FAIL b2b_next_line: got %h want %h", dut_snap(), mdl_snap());
        end
        cycle(0, 8'h00, 1);
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         n, r, w;
        for (int l = 0; l < 25; l++) begin
            n = $urandom_range(0, 40);
            for (int j = 0; j < n; j++) begin
                r = $urandom_range(0, 99);
                if (r < 8)       b = 8'h0D;
                else if (r < 11) b = 8'h08;
                else if (r < 14) b = 8'h7F;
                else             b = 8'($urandom_range(32, 126));
                cycle(($urandom_range(0, 3) != 0), b, 1'($urandom_range(0, 1)));
                n_checks++;
                if (dut_snap() !== mdl_snap()) begin
                    n_fail++;
                    $display("FAIL random_collect: got %h want %h", dut_snap(), mdl_snap());
                end
            end
            cycle(1, LF, 0);
            w = $urandom_range(0, 4);
            for (int k = 0; k <= w; k++) begin
                cycle(1'($urandom_range(0, 1)), 8'($urandom_range(32, 126)), (k == w));
                n_checks++;
                if (dut_snap() !== mdl_snap()) begin
                    n_fail++;
                    $display("FAIL random_pending: got %h want %h", dut_snap(), mdl_snap());
                end
            end
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_basic();
        test_overflow();
        test_pending_drop();
        test_empty_line();
        test_backspace();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
